// File: rtl/gnn_pkg.sv
// Shared constants, types and helpers for the GNN result interface consumer.
package gnn_pkg;

  localparam int NUM_NODES = 4;
  localparam int NUM_OUTS  = 2;
  localparam int NUM_WORDS = NUM_NODES * NUM_OUTS;
  localparam int RES_W     = 21;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  typedef logic signed [RES_W-1:0] res_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  // Flat word index of a node output: k = node*2 + out.
  function automatic logic [IDX_W-1:0] word_idx(input int node, input int out);
    return IDX_W'(node * NUM_OUTS + out);
  endfunction

endpackage

// File: rtl/gnn_sat_narrow.sv
// Combinational signed RES_W -> OUT_W narrower with a clip indicator.
// GNN_SER_SAT_EN selects saturation; otherwise two's-complement wrap.
module gnn_sat_narrow #(
  parameter int RES_W = 21,
  parameter int OUT_W = 16
) (
  input  logic signed [RES_W-1:0] din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic [OUT_W-1:0] MIN_V = OUT_W'(1) << (OUT_W - 1);

  // The word fits iff every bit from the target sign bit upward agrees.
  logic [RES_W-OUT_W:0] upper;
  assign upper = din[RES_W-1:OUT_W-1];
  assign clip  = !((&upper) || (~|upper));

`ifdef GNN_SER_SAT_EN
  always_comb begin
    dout = din[OUT_W-1:0];
    if (clip) dout = din[RES_W-1] ? MIN_V : ~MIN_V;
  end
`else
  assign dout = din[OUT_W-1:0];
`endif

endmodule

// File: rtl/gnn_result_serializer.sv
// Snapshots the eight GNN results on the rising edge of "all ready" and
// streams them over valid/ready. Optional saturation: GNN_SER_SAT_EN.
module gnn_result_serializer
  import gnn_pkg::ser_state_e, gnn_pkg::IDLE, gnn_pkg::SEND, gnn_pkg::word_idx,
         gnn_pkg::NUM_NODES, gnn_pkg::NUM_OUTS;
#(
  parameter int RES_W     = gnn_pkg::RES_W,
  parameter int OUT_W     = 16,
  parameter int NUM_WORDS = gnn_pkg::NUM_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WORDS*RES_W-1:0] res_data,
  input  logic [NUM_WORDS-1:0]       res_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [OUT_W-1:0]    m_data,
  output logic [2:0]                 m_idx,
  output logic                       m_last,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clr_overrun
`ifdef GNN_SER_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

  ser_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d, idx_nxt;
  logic       all_rdy, all_rdy_q, cap_evt, fire;
  logic       load, advance;

  logic signed [RES_W-1:0] buffer [NUM_WORDS];
  logic signed [RES_W-1:0] nxt_word;
  logic signed [OUT_W-1:0] nxt_data;
  logic                    nxt_clip;

  assign all_rdy = &res_ready;
  assign cap_evt = all_rdy & ~all_rdy_q;
  assign fire    = m_valid & m_ready;
  assign idx_nxt = idx_q + 3'd1;

  assign m_valid = (state_q == SEND);
  assign busy    = (state_q == SEND);
  assign m_idx   = idx_q;

  // NOTE: next-state logic assigns every output a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_evt) begin
          load    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            advance = 1'b1;
            idx_d   = idx_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // On capture the first word bypasses the buffer so it appears one cycle later.
  assign nxt_word = load ? res_data[RES_W-1:0] : buffer[idx_nxt];

  gnn_sat_narrow #(
    .RES_W (RES_W),
    .OUT_W (OUT_W)
  ) u_narrow (
    .din  (nxt_word),
    .dout (nxt_data),
    .clip (nxt_clip)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      all_rdy_q <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      all_rdy_q <= all_rdy;
      m_last    <= (state_d == SEND) && (idx_d == LAST_IDX);
      if (load || advance) m_data <= nxt_data;
      // A new snapshot while streaming is dropped; set beats a same-cycle clear.
      if (cap_evt && (state_q == SEND)) overrun <= 1'b1;
      else if (clr_overrun)             overrun <= 1'b0;
    end
  end

  // NOTE: the snapshot buffer is small and has a defined reset value, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) buffer[k] <= '0;
    end else if (load) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        for (int o = 0; o < NUM_OUTS; o++) begin
          buffer[int'(word_idx(n, o))] <= res_data[int'(word_idx(n, o))*RES_W +: RES_W];
        end
      end
    end
  end

`ifdef GNN_SER_SAT_EN
  logic m_clip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clip_q <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (load || advance) m_clip_q <= nxt_clip;
      if (fire && m_clip_q) sat_flag <= 1'b1;
      else if (clr_overrun) sat_flag <= 1'b0;
    end
  end
`else
  logic unused_clip;
  assign unused_clip = nxt_clip;
`endif

endmodule

// File: tb/tb_gnn_result_serializer.sv
// Directed self-checking bench for gnn_result_serializer (default and GNN_SER_SAT_EN builds).
module tb_gnn_result_serializer;

  localparam int RES_W = 21;
  localparam int OUT_W = 16;
  localparam int NW    = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NW*RES_W-1:0]    res_data = '0;
  logic [NW-1:0]          res_ready = '0;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic signed [OUT_W-1:0] m_data;
  logic [2:0]             m_idx;
  logic                   m_last;
  logic                   busy;
  logic                   overrun;
  logic                   clr_overrun = 1'b0;
`ifdef GNN_SER_SAT_EN
  logic                   sat_flag;
`endif

  int total = 0;
  int bad   = 0;
  int wv [NW];
  logic signed [OUT_W-1:0] exp_d [NW];

  gnn_result_serializer #(
    .RES_W (RES_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_idx       (m_idx),
    .m_last      (m_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
`ifdef GNN_SER_SAT_EN
    ,
    .sat_flag    (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic load_words();
    for (int k = 0; k < NW; k++) res_data[k*RES_W +: RES_W] = RES_W'(wv[k]);
  endtask

  task automatic idle_cycle();
    res_ready = '0;
    m_ready   = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0 repeating.
  // inject_at >= 0 re-triggers a capture with new data while that word is shown.
  task automatic run_stream(input string name, input int mode, input int inject_at);
    int hs = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic signed [OUT_W-1:0] prev_d = '0;
    logic [2:0] prev_i = '0;
    bit injected = 1'b0;
    bit rearm = 1'b0;
    res_ready = 8'hFF;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_idx !== 3'd0) begin
      bad++;
      $display("FAIL %s latency: m_valid=%b m_idx=%0d expected 1/0", name, m_valid, m_idx);
    end
    while (hs < NW && cyc < 60) begin
      m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (rearm) begin
        res_ready = 8'hFF;
        rearm = 1'b0;
      end
      if (inject_at >= 0 && !injected && m_valid && m_idx == 3'(inject_at)) begin
        for (int k = 0; k < NW; k++) wv[k] = 100 + k;
        load_words();
        res_ready = '0;
        injected = 1'b1;
        rearm = 1'b1;
      end
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_d || m_idx !== prev_i) begin
          bad++;
          $display("FAIL %s stall: v=%b d=%0d i=%0d expected 1/%0d/%0d", name,
                   m_valid, m_data, m_idx, prev_d, prev_i);
        end
      end
      if (mode == 0) begin
        total++;
        if (m_valid !== 1'b1) begin
          bad++;
          $display("FAIL %s bubble: m_valid=%b expected 1 at word %0d", name, m_valid, hs);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        total++;
        if (m_data !== exp_d[hs] || m_idx !== 3'(hs) || m_last !== (hs == NW - 1)) begin
          bad++;
          $display("FAIL %s word%0d: d=%0d i=%0d last=%b expected %0d/%0d/%b", name, hs,
                   m_data, m_idx, m_last, exp_d[hs], hs, (hs == NW - 1));
        end
        hs++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_i = m_idx;
      @(negedge clk);
      cyc++;
    end
    if (hs < NW) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d words expected %0d", name, hs, NW);
    end
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL %s end: v=%b busy=%b last=%b expected 0/0/0", name, m_valid, busy, m_last);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_idx !== 3'd0 || m_last !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL %s: v=%b d=%0d i=%0d last=%b busy=%b ovr=%b expected all 0", name,
               m_valid, m_data, m_idx, m_last, busy, overrun);
    end
`ifdef GNN_SER_SAT_EN
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL %s sat_flag: got %b expected 0", name, sat_flag);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");
  endtask

  task automatic test_single();
    idle_cycle();
    wv = '{1, -2, 3, -4, 5, -6, 7, -8};
    exp_d = '{16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd5, -16'sd6, 16'sd7, -16'sd8};
    load_words();
    run_stream("single", 0, -1);
    for (int c = 0; c < 12; c++) begin
      total++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL single held_level c%0d: v=%b busy=%b expected 0/0", c, m_valid, busy);
      end
      @(negedge clk);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL single overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    wv = '{-100, 200, -300, 400, -500, 600, -700, 800};
    exp_d = '{-16'sd100, 16'sd200, -16'sd300, 16'sd400, -16'sd500, 16'sd600, -16'sd700, 16'sd800};
    load_words();
    run_stream("backpressure", 1, -1);
  endtask

  task automatic test_overrun();
    idle_cycle();
    wv = '{11, 12, 13, 14, 15, 16, 17, 18};
    exp_d = '{16'sd11, 16'sd12, 16'sd13, 16'sd14, 16'sd15, 16'sd16, 16'sd17, 16'sd18};
    load_words();
    run_stream("overrun", 0, 3);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun set: got %b expected 1", overrun);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun clear: got %b expected 0", overrun);
    end
  endtask

  task automatic test_partial();
    idle_cycle();
    res_ready = 8'h7F;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL partial c%0d: v=%b busy=%b expected 0/0", c, m_valid, busy);
      end
    end
  endtask

  task automatic test_narrow();
    idle_cycle();
    wv = '{40000, -40000, 0, 0, 0, 0, 0, 0};
`ifdef GNN_SER_SAT_EN
    exp_d = '{16'sd32767, -16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
`else
    exp_d = '{-16'sd25536, 16'sd25536, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
`endif
    load_words();
    run_stream("narrow", 0, -1);
`ifdef GNN_SER_SAT_EN
    total++;
    if (sat_flag !== 1'b1) begin
      bad++;
      $display("FAIL sat_flag set: got %b expected 1", sat_flag);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL sat_flag clear: got %b expected 0", sat_flag);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    idle_cycle();
    wv = '{1, 2, 3, 4, 5, 6, 7, 8};
    exp_d = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
    load_words();
    res_ready = 8'hFF;
    @(negedge clk);
    while (m_idx !== 3'd4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (m_idx !== 3'd4 || m_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid reach: i=%0d v=%b expected 4/1", m_idx, m_valid);
    end
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid async");
    res_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_stream("restart", 0, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_partial();
    test_narrow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gnn_result_serializer.md
Name: gnn_result_serializer

Overview:
- Consumer end of the GNN top-level result interface.
- Watches the eight per-node output-ready flags (node0..node3, out0/out1).
- When all eight are high, snapshots the eight signed 21-bit aggregated results into a local buffer.
- Streams the snapshot word by word over a valid/ready handshake to the downstream host/readout logic, optionally narrowing each word.

Parameters:
- RES_W, 21, width of each incoming signed result word.
- OUT_W, 16, width of each streamed signed word (1..RES_W).
- NUM_WORDS, 8, results per snapshot (4 nodes x 2 outputs); fixed by the package, not overridable in practice.

Ports:
- clk  in  1  system clock; all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- res_data  in  NUM_WORDS*RES_W  packed results; word k at bits [k*RES_W +: RES_W], k = node*2 + out (k0 = out0_node0, k1 = out1_node0, ... k7 = out1_node3).
- res_ready  in  NUM_WORDS  packed ready flags, same index order (k0 = out10_ready_node0, ...).
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  OUT_W  signed stream word.
- m_idx  out  3  index k of the current word.
- m_last  out  1  high with word k = 7.
- busy  out  1  snapshot held / streaming in progress.
- overrun  out  1  sticky: a new snapshot event arrived while busy.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, overrun=0; internal all_rdy_q=0, buffer=0, state=IDLE.
- all_rdy = &res_ready; all_rdy_q registers it each cycle.
- Capture event: all_rdy & ~all_rdy_q (rising edge only). A level held high across many cycles produces exactly one event.
- FSM IDLE:
  - On a capture event at edge N, load all 8 words into the buffer and set idx=0, busy=1, m_valid=1.
  - Enter SEND. First word is visible in the cycle after edge N.
- FSM SEND:
  - m_data = narrow(buffer[idx]) and m_idx = idx, both registered.
  - m_last = (idx==7).
  - On m_valid & m_ready: if idx<7, idx++ and present the next word on the following cycle, with no bubbles.
  - If idx==7: m_valid=0, busy=0, go to IDLE.
- m_valid is never withdrawn and m_data is never changed while m_ready=0 (AXI-style stability).
- Capture event while in SEND (including the final handshake cycle): new data is dropped, the buffer is unchanged, and overrun is set to 1.
- overrun stays set until clr_overrun=1 or reset. If a set and a clear occur in the same cycle, set wins.
- Capture event in IDLE on the same edge that SEND completed: cannot occur. Completion moves to IDLE, so the event is treated as during SEND, i.e. dropped with overrun.
- Narrowing, without the macro: m_data = low OUT_W bits of the word (two's-complement wrap).
- OUT_W == RES_W passes words through unchanged.
- Reset asserted mid-stream: all state returns to reset values immediately; the partial stream is abandoned, with no m_last.
- Latency: capture edge to first m_valid = 1 cycle; 8 words in 8 cycles with m_ready held high.

Optional Feature:
- Macro: GNN_SER_SAT_EN.
- Defined: narrowing saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and a sticky output port sat_flag (1 bit, reset 0, cleared by clr_overrun) sets when any streamed word is clipped.
- Undefined: wrap truncation as above, and the sat_flag port does not exist.

Decomposition:
- Shared package gnn_pkg:
  - NUM_NODES=4, NUM_OUTS=2, NUM_WORDS=8, RES_W=21.
  - typedef logic signed [RES_W-1:0] res_t.
  - typedef enum {IDLE, SEND} ser_state_e.
  - Function word_idx(node, out) returning node*2 + out.
- One sub-module: gnn_sat_narrow, a combinational RES_W->OUT_W narrower holding both the saturate and wrap paths under the macro, plus a clip indicator.

Test Plan:
- Single snapshot: words k0..k7 = 1,-2,3,-4,5,-6,7,-8; res_ready 0->FF held 20 cycles; m_ready=1 -> exactly one stream with m_data 1,-2,...,-8 and m_idx 0..7 on consecutive cycles, m_last only at idx 7, busy low afterwards, overrun=0.
- Backpressure: m_ready toggled 1,0,0,1,... -> m_data/m_idx stable while stalled; all 8 words delivered in order with no duplicates.
- Overrun: res_ready drops to 00 then back to FF during word 3 with new data 100s -> the stream still carries the original values and overrun=1. After clr_overrun pulse, overrun=0.
- Partial ready: res_ready=7F indefinitely -> m_valid never asserts, busy=0.
- Narrowing with OUT_W=16 and word 40000 / -40000:
  - without GNN_SER_SAT_EN: -25536 / 25536.
  - with GNN_SER_SAT_EN: 32767 / -32768, sat_flag=1.
- Reset mid-stream: rst_n low during word 4 -> all outputs 0 asynchronously. A fresh FF edge after release restarts the stream at idx 0.
